// File: rtl/dmem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_arbiter_pkg
// Brief   : Shared types and constants for the data-memory arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package dmem_arbiter_pkg;

  // Arbiter FSM: free arbitration, or m1 holding the port via its lock hint
  typedef enum logic {
    ARB     = 1'b0,
    LOCK_M1 = 1'b1
  } arb_state_e;

  // Requester identity, used for read ownership and the round-robin flop
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_id_e;

  // Start of the MMIO window; m1 accesses at or above it are blocked
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  // Load/store format codes (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : dmem_arbiter
// Brief   : Two-requester arbiter for a single data-memory port. m0 is the
//           core, m1 a loader/debug master with a lock hint and a blocked
//           MMIO window. Grants are combinational; read data returns one
//           cycle after the grant to the requester that owned the read.
// Config  : DMEM_ARB_RR_EN - round-robin conflict resolution (default: m0
//           always wins conflicts in ARB).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter #(
  parameter int XLEN = 32,
  parameter int ALEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // core requester
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [3:0]      m0_be,
  input  logic [2:0]      m0_funct3,
  input  logic [ALEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  // loader/debug requester
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [3:0]      m1_be,
  input  logic [2:0]      m1_funct3,
  input  logic [ALEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic            m1_err,
  output logic [XLEN-1:0] m1_rdata,
  // memory port
  output logic            mem_write,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  import dmem_arbiter_pkg::*;

  arb_state_e state, state_nxt;
  logic       rd_pend;   // a read was granted last cycle
  req_id_e    rd_owner;  // who owns the returning read
  logic       rd_blk;    // the returning read was a blocked MMIO access
  logic       m1_mmio;

`ifdef DMEM_ARB_RR_EN
  req_id_e    last_grant;
`endif

  // MMIO space is the upper half of the address map (MMIO_BASE)
  assign m1_mmio = m1_addr[ALEN-1];

  // Grant selection and next-state logic; nothing is granted while in reset
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            if (last_grant == M1) m0_gnt = 1'b1;
            else                  m1_gnt = 1'b1;
`else
            m0_gnt = 1'b1;
`endif
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
          if (m1_gnt && m1_lock) state_nxt = LOCK_M1;
        end
        LOCK_M1: begin
          m1_gnt = m1_req;
          if (!m1_lock) state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // Route the granted requester onto the memory port; blocked MMIO is zeroed
  always_comb begin
    mem_write  = 1'b0;
    mem_be     = '0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (m0_gnt) begin
      mem_write  = m0_we;
      mem_be     = m0_be;
      mem_funct3 = m0_funct3;
      mem_addr   = m0_addr;
      mem_wdata  = m0_wdata;
    end else if (m1_gnt && !m1_mmio) begin
      mem_write  = m1_we;
      mem_be     = m1_be;
      mem_funct3 = m1_funct3;
      mem_addr   = m1_addr;
      mem_wdata  = m1_wdata;
    end
  end

  assign m1_err = m1_gnt & m1_mmio;

  // Read return steering; a blocked m1 read completes with zero data
  always_comb begin
    m0_rvalid = rd_pend && (rd_owner == M0);
    m1_rvalid = rd_pend && (rd_owner == M1);
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = (m1_rvalid && !rd_blk) ? mem_rdata : '0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  // Track the outstanding read so returns follow grant order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= M0;
      rd_blk   <= 1'b0;
    end else begin
      rd_pend  <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
      rd_owner <= m1_gnt ? M1 : M0;
      rd_blk   <= m1_gnt && m1_mmio;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the most recent winner for round-robin fairness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= M1;
    else if (m0_gnt) last_grant <= M0;
    else if (m1_gnt) last_grant <= M1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_dmem_arbiter
// Brief   : Directed, table-driven self-checking bench for dmem_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

  import dmem_arbiter_pkg::*;

  typedef struct {
    logic        m0_req, m0_we;
    logic [3:0]  m0_be;
    logic [2:0]  m0_f3;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata, mem_rdata;
    logic        e_m0_gnt, e_m0_rv;
    logic [31:0] e_m0_rd;
    logic        e_m1_gnt, e_m1_rv, e_m1_err;
    logic [31:0] e_m1_rd;
    logic        e_mw;
    logic [3:0]  e_be;
    logic [2:0]  e_f3;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  localparam logic [3:0] F = 4'hF;
  localparam logic [2:0] W = F3_LW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]  m0_be;
  logic [2:0]  m0_funct3;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [3:0]  m1_be;
  logic [2:0]  m1_funct3;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_write;
  logic [3:0]  mem_be;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  dmem_arbiter #(.XLEN(32), .ALEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_funct3(m0_funct3),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_be(m1_be),
    .m1_funct3(m1_funct3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_write(mem_write), .mem_be(mem_be), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic a_m0_req, a_m0_we, input logic [3:0] a_m0_be, input logic [2:0] a_m0_f3,
    input logic [31:0] a_m0_addr, a_m0_wdata,
    input logic a_m1_req, a_m1_we, a_m1_lock, input logic [31:0] a_m1_addr, a_m1_wdata,
    input logic [31:0] a_mem_rdata,
    input logic x_m0_gnt, x_m0_rv, input logic [31:0] x_m0_rd,
    input logic x_m1_gnt, x_m1_rv, x_m1_err, input logic [31:0] x_m1_rd,
    input logic x_mw, input logic [3:0] x_be, input logic [2:0] x_f3,
    input logic [31:0] x_addr, x_wdata);
    vec_t v;
    v.m0_req = a_m0_req; v.m0_we = a_m0_we; v.m0_be = a_m0_be; v.m0_f3 = a_m0_f3;
    v.m0_addr = a_m0_addr; v.m0_wdata = a_m0_wdata;
    v.m1_req = a_m1_req; v.m1_we = a_m1_we; v.m1_lock = a_m1_lock;
    v.m1_addr = a_m1_addr; v.m1_wdata = a_m1_wdata; v.mem_rdata = a_mem_rdata;
    v.e_m0_gnt = x_m0_gnt; v.e_m0_rv = x_m0_rv; v.e_m0_rd = x_m0_rd;
    v.e_m1_gnt = x_m1_gnt; v.e_m1_rv = x_m1_rv; v.e_m1_err = x_m1_err; v.e_m1_rd = x_m1_rd;
    v.e_mw = x_mw; v.e_be = x_be; v.e_f3 = x_f3; v.e_addr = x_addr; v.e_wdata = x_wdata;
    return v;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    m0_req = v.m0_req; m0_we = v.m0_we; m0_be = v.m0_be; m0_funct3 = v.m0_f3;
    m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_lock = v.m1_lock;
    m1_addr = v.m1_addr; m1_wdata = v.m1_wdata; mem_rdata = v.mem_rdata;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk(tag, "m0_gnt",     {31'd0, m0_gnt},     {31'd0, v.e_m0_gnt});
    chk(tag, "m0_rvalid",  {31'd0, m0_rvalid},  {31'd0, v.e_m0_rv});
    chk(tag, "m0_rdata",   m0_rdata,            v.e_m0_rd);
    chk(tag, "m1_gnt",     {31'd0, m1_gnt},     {31'd0, v.e_m1_gnt});
    chk(tag, "m1_rvalid",  {31'd0, m1_rvalid},  {31'd0, v.e_m1_rv});
    chk(tag, "m1_err",     {31'd0, m1_err},     {31'd0, v.e_m1_err});
    chk(tag, "m1_rdata",   m1_rdata,            v.e_m1_rd);
    chk(tag, "mem_write",  {31'd0, mem_write},  {31'd0, v.e_mw});
    chk(tag, "mem_be",     {28'd0, mem_be},     {28'd0, v.e_be});
    chk(tag, "mem_funct3", {29'd0, mem_funct3}, {29'd0, v.e_f3});
    chk(tag, "mem_addr",   mem_addr,            v.e_addr);
    chk(tag, "mem_wdata",  mem_wdata,           v.e_wdata);
  endtask

  // One cycle: drive after the rising edge, compare on the falling edge
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1;
    drive_vec(v);
    @(negedge clk);
    check_vec(v, tag);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    m1_be = F; m1_funct3 = W;
    // Requests held high during reset must not be granted
    v = mk(1,1,F,W,32'h104,32'h5, 1,1,0,32'h300,32'h9, 32'h0,
           0,0,0, 0,0,0,0, 0,0,0,0,0);
    drive_vec(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec(v, "reset");
    v = mk(0,0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0);
    drive_vec(v);
    rst_n = 1'b1;

    // Directed single-cycle table
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'hDEAD,
                      0,0,0, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,F,W,32'h100,0, 0,0,0,0,0, 32'h1111_1111,
                      1,0,0, 0,0,0,0, 0,F,W,32'h100,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,32'h200,0, 32'hCAFE_0001,
                      0,1,32'hCAFE_0001, 1,0,0,0, 0,F,W,32'h200,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'hBEEF_0002,
                      0,0,0, 0,1,0,32'hBEEF_0002, 0,0,0,0,0));
    vecs.push_back(mk(1,1,4'b0011,F3_LH,32'h104,32'h1234_5678, 0,0,0,0,0, 32'h55,
                      1,0,0, 0,0,0,0, 1,4'b0011,F3_LH,32'h104,32'h1234_5678));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'h66,
                      0,0,0, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0,32'h8000_0000,32'hAAAA, 32'h0,
                      0,0,0, 1,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,32'h8000_0004,0, 32'h77,
                      0,0,0, 1,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'h99,
                      0,0,0, 0,1,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,F,W,32'h104,32'h5, 0,1,0,32'h300,32'h9, 32'h0,
                      0,0,0, 0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0,32'h300,32'h0BAD_F00D, 32'h0,
                      0,0,0, 1,0,0,0, 1,F,W,32'h300,32'h0BAD_F00D));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Write conflict between both requesters
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        apply(mk(1,1,F,W,32'h600,32'h66, 1,1,0,32'h700,32'h77, 0,
                 1,0,0, 0,0,0,0, 1,F,W,32'h600,32'h66), $sformatf("rr%0d", i));
      else
        apply(mk(1,1,F,W,32'h600,32'h66, 1,1,0,32'h700,32'h77, 0,
                 0,0,0, 1,0,0,0, 1,F,W,32'h700,32'h77), $sformatf("rr%0d", i));
    end
`else
    apply(mk(1,1,F,W,32'h600,32'h66, 1,1,0,32'h700,32'h77, 0,
             1,0,0, 0,0,0,0, 1,F,W,32'h600,32'h66), "conf0");
    apply(mk(0,0,0,0,0,0, 1,1,0,32'h700,32'h77, 0,
             0,0,0, 1,0,0,0, 1,F,W,32'h700,32'h77), "conf1");
`endif

    // m1 locked reads starve m0 until the edge after lock drops
    apply(mk(0,0,0,0,0,0, 1,0,1,32'h200,0, 0,
             0,0,0, 1,0,0,0, 0,F,W,32'h200,0), "lock0");
    apply(mk(1,0,F,W,32'h104,0, 1,0,1,32'h204,0, 32'hA1,
             0,0,0, 1,1,0,32'hA1, 0,F,W,32'h204,0), "lock1");
    apply(mk(1,0,F,W,32'h104,0, 1,0,1,32'h208,0, 32'hA2,
             0,0,0, 1,1,0,32'hA2, 0,F,W,32'h208,0), "lock2");
    apply(mk(1,0,F,W,32'h104,0, 0,0,0,0,0, 32'hA3,
             0,0,0, 0,1,0,32'hA3, 0,0,0,0,0), "lock3");
    apply(mk(1,0,F,W,32'h104,0, 0,0,0,0,0, 32'hA4,
             1,0,0, 0,0,0,0, 0,F,W,32'h104,0), "lock4");
    apply(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'hA5,
             0,1,32'hA5, 0,0,0,0, 0,0,0,0,0), "lock5");

    // Reset while locked with a read pending discards both
    apply(mk(0,0,0,0,0,0, 1,0,1,32'h400,0, 0,
             0,0,0, 1,0,0,0, 0,F,W,32'h400,0), "rst0");
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    check_vec(mk(0,0,0,0,0,0, 1,0,1,32'h400,0, 32'hBAD0_BAD0,
                 0,0,0, 0,0,0,0, 0,0,0,0,0), "rst1");
    @(negedge clk);
    check_vec(mk(0,0,0,0,0,0, 1,0,1,32'h400,0, 32'hBAD0_BAD0,
                 0,0,0, 0,0,0,0, 0,0,0,0,0), "rst2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = mk(1,0,F,W,32'h500,0, 0,0,0,0,0, 32'hBAD1,
           1,0,0, 0,0,0,0, 0,F,W,32'h500,0);
    drive_vec(v);
    @(negedge clk);
    check_vec(v, "rst3");
    apply(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'hF00D,
             0,1,32'hF00D, 0,0,0,0, 0,0,0,0,0), "rst4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
